// File: rtl/ip_tx_frame_buffer.sv
// Store-and-forward tx buffer: 32-bit datagram words in, committed packets replayed as a
// byte stream trimmed to the IPv4 total length; whole packets are dropped on overflow.
module ip_tx_frame_buffer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned SLOT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pkg_data,
  input  logic              wr_en,
  input  logic              fin,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              drop,
  output logic [SLOT_W:0]   pkt_pend
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned SLOTS = 1 << SLOT_W;

  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SLOT_W:0]   slot_t;
  typedef enum logic [1:0] {IDLE, HDR, SEND} state_t;

  localparam addr_t CNT_MAX   = '1;
  localparam ptr_t  PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam addr_t ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam slot_t SLOT_ONE  = {{SLOT_W{1'b0}}, 1'b1};
  localparam slot_t PEND_FULL = {1'b1, {SLOT_W{1'b0}}};

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  ptr_t   wr_ptr, commit_ptr, rd_base;
  addr_t  word_cnt;
  logic   dropping;
  ptr_t   desc_start [SLOTS];
  addr_t  desc_cnt   [SLOTS];
  slot_t  dwp, drp;

  state_t      state;
  ptr_t        cur_start;
  addr_t       cur_cnt, nxt_addr, rd_addr, eff_cnt;
  logic [31:0] sh;
  logic [15:0] byte_idx, byte_len, max_bytes, hdr_len;

  logic wr_full, word_ovf, do_write, fin_drop, commit;
  logic desc_avail, accept, last_accept;

  assign out_data = sh[31:24];

  always_comb begin
    // Full when the write pointer has lapped the start of the oldest unsent packet.
    wr_full     = (wr_ptr[ADDR_W] != rd_base[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_base[ADDR_W-1:0]);
    word_ovf    = wr_en && !dropping && (wr_full || word_cnt == CNT_MAX);
    do_write    = wr_en && !dropping && !word_ovf;
    eff_cnt     = word_cnt + addr_t'(do_write);
    fin_drop    = fin && (dropping || word_ovf || (eff_cnt != '0 && pkt_pend == PEND_FULL));
    commit      = fin && !fin_drop && eff_cnt != '0;
    desc_avail  = dwp != drp;
    accept      = out_valid && out_ready;
    last_accept = accept && out_last;
    rd_addr     = (state == IDLE || last_accept) ? desc_start[drp[SLOT_W-1:0]][ADDR_W-1:0]
                                                 : nxt_addr;
    max_bytes   = 16'({cur_cnt, 2'b00});
    hdr_len     = (rd_q[15:0] == '0 || rd_q[15:0] > max_bytes) ? max_bytes : rd_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= pkg_data;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      word_cnt   <= '0;
      dropping   <= 1'b0;
      drop       <= 1'b0;
      dwp        <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        desc_start[i] <= '0;
        desc_cnt[i]   <= '0;
      end
    end else begin
      drop <= fin_drop;
      if (fin) begin
        dropping <= 1'b0;
        word_cnt <= '0;
        if (fin_drop)      wr_ptr <= commit_ptr;
        else if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
        if (commit) begin
          desc_start[dwp[SLOT_W-1:0]] <= commit_ptr;
          desc_cnt[dwp[SLOT_W-1:0]]   <= eff_cnt;
          dwp        <= dwp + SLOT_ONE;
          commit_ptr <= wr_ptr + ptr_t'(do_write);
        end
      end else if (word_ovf) begin
        dropping <= 1'b1;
        wr_ptr   <= commit_ptr;
        word_cnt <= '0;
      end else if (do_write) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        word_cnt <= word_cnt + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drp       <= '0;
      rd_base   <= '0;
      cur_start <= '0;
      cur_cnt   <= '0;
      nxt_addr  <= '0;
      sh        <= '0;
      byte_idx  <= '0;
      byte_len  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pkt_pend  <= '0;
    end else begin
      if (commit && !last_accept)      pkt_pend <= pkt_pend + SLOT_ONE;
      else if (!commit && last_accept) pkt_pend <= pkt_pend - SLOT_ONE;

      unique case (state)
        IDLE: begin
          if (desc_avail) begin
            cur_start <= desc_start[drp[SLOT_W-1:0]];
            cur_cnt   <= desc_cnt[drp[SLOT_W-1:0]];
            nxt_addr  <= desc_start[drp[SLOT_W-1:0]][ADDR_W-1:0] + ADDR_ONE;
            drp       <= drp + SLOT_ONE;
            state     <= HDR;
          end
        end
        HDR: begin
          sh        <= rd_q;
          byte_len  <= hdr_len;
          byte_idx  <= '0;
          out_valid <= 1'b1;
          out_last  <= hdr_len == 16'd1;
          state     <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (out_last) begin
              // Skip pad words and chain straight into the next packet header if queued.
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_base   <= cur_start + ptr_t'(cur_cnt);
              if (desc_avail) begin
                cur_start <= desc_start[drp[SLOT_W-1:0]];
                cur_cnt   <= desc_cnt[drp[SLOT_W-1:0]];
                nxt_addr  <= desc_start[drp[SLOT_W-1:0]][ADDR_W-1:0] + ADDR_ONE;
                drp       <= drp + SLOT_ONE;
                state     <= HDR;
              end else begin
                state <= IDLE;
              end
            end else begin
              byte_idx <= byte_idx + 16'd1;
              out_last <= (byte_idx + 16'd2) == byte_len;
              if (byte_idx[1:0] == 2'd3) begin
                sh       <= rd_q;
                nxt_addr <= nxt_addr + ADDR_ONE;
              end else begin
                sh <= {sh[23:0], 8'h00};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
